// File: rtl/evm_pkg.sv
// Shared FSM state type, default frame header and frame-length constants for the tally UART transmitter.
package evm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    NEXT_BYTE
  } tx_state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN_BASE = 5;
  localparam int         FRAME_LEN_CSUM = 6;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; a load while idle or in the last stop-bit cycle drives the start bit on the next cycle.
// No backpressure: i_load outside those two windows is ignored.
module uart_tx_byte
  import evm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_stop_end
);

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  tx_state_e   r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_busy;
  logic        w_bit_end;

  assign w_bit_end  = (r_baud == BAUD_MAX);
  assign o_stop_end = (r_state == STOP_BIT) && w_bit_end;
  assign o_tx       = r_tx;
  assign o_busy     = r_busy;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_load) begin
            r_state   <= START_BIT;
            r_shift   <= i_data;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        START_BIT: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= DATA_BITS;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        DATA_BITS: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
              r_state   <= STOP_BIT;
              r_tx      <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        STOP_BIT: begin
          // The next-byte decision overlaps the stop bit's last cycle so bytes run back-to-back.
          if (w_bit_end) begin
            r_baud <= '0;
            if (i_load) begin
              r_state <= START_BIT;
              r_shift <= i_data;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tally_uart_tx.sv
// Sends a snapshot of four vote tallies as HEADER,c1..c4[,xor checksum when TALLY_CHECKSUM_EN] over 8N1 UART.
// Start bit appears the cycle after acceptance; requests while busy or in the done cycle are dropped.
module tally_uart_tx
  import evm_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       start,
  input  logic [7:0] cand1_vote,
  input  logic [7:0] cand2_vote,
  input  logic [7:0] cand3_vote,
  input  logic [7:0] cand4_vote,
  output logic       tx,
  output logic       busy,
  output logic       done
);

`ifdef TALLY_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN_CSUM - 1);
`else
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN_BASE - 1);
`endif

  logic [7:0] r_c1, r_c2, r_c3, r_c4;
  logic [2:0] r_byte_idx;
  logic       r_busy;
  logic       r_done;

  logic       w_accept;
  logic       w_stop_end;
  logic       w_byte_busy;
  logic       w_last;
  logic       w_more;
  logic       w_frame_end;
  logic       w_load;
  logic [2:0] w_next_idx;
  logic [7:0] w_next_byte;
  logic [7:0] w_load_data;

`ifdef TALLY_CHECKSUM_EN
  logic [7:0] w_csum;
  assign w_csum = r_c1 ^ r_c2 ^ r_c3 ^ r_c4;
`endif

  assign w_accept    = start & mode & ~r_busy & ~r_done & ~w_byte_busy;
  assign w_last      = (r_byte_idx == LAST_IDX);
  assign w_more      = r_busy & w_stop_end & ~w_last;
  assign w_frame_end = r_busy & w_stop_end & w_last;
  assign w_next_idx  = r_byte_idx + 3'd1;
  assign w_load      = w_accept | w_more;
  // The header needs no snapshot, so it can be loaded on the acceptance edge itself.
  assign w_load_data = w_accept ? HEADER : w_next_byte;

  always_comb begin
    w_next_byte = HEADER;
    case (w_next_idx)
      3'd1:    w_next_byte = r_c1;
      3'd2:    w_next_byte = r_c2;
      3'd3:    w_next_byte = r_c3;
      3'd4:    w_next_byte = r_c4;
`ifdef TALLY_CHECKSUM_EN
      3'd5:    w_next_byte = w_csum;
`endif
      default: w_next_byte = HEADER;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_c1       <= '0;
      r_c2       <= '0;
      r_c3       <= '0;
      r_c4       <= '0;
      r_byte_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_byte_idx <= '0;
        r_c1       <= cand1_vote;
        r_c2       <= cand2_vote;
        r_c3       <= cand3_vote;
        r_c4       <= cand4_vote;
      end else if (w_more) begin
        r_byte_idx <= w_next_idx;
      end else if (w_frame_end) begin
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
        r_byte_idx <= '0;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .i_clk      (clock),
    .i_reset    (reset),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .o_tx       (tx),
    .o_busy     (w_byte_busy),
    .o_stop_end (w_stop_end)
  );

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_tally_uart_tx.sv
// Scoreboard bench for tally_uart_tx: stimulus queues expected bytes, a UART receiver pops and compares.
`timescale 1ns/1ps
module tb_tally_uart_tx;

  localparam int CPB = 4;
`ifdef TALLY_CHECKSUM_EN
  localparam int FLEN = 6;
`else
  localparam int FLEN = 5;
`endif
  localparam int BUSY_LEN = FLEN * 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode  = 1'b0;
  logic       start = 1'b0;
  logic [7:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0;
  logic       tx, busy, done;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int done_cnt = 0;
  int overlap_cnt = 0;
  int busy_run = 0;
  int last_busy_len = 0;
  int bad = 0;
  int d0 = 0;

  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  int         rx_bit = 0;
  logic [7:0] rx_byte = '0;
  logic [7:0] rx_exp = '0;

  always #5 clock = ~clock;

  tally_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .HEADER      (8'hA5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .start     (start),
    .cand1_vote(c1),
    .cand2_vote(c2),
    .cand3_vote(c3),
    .cand4_vote(c4),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Receiver and line monitor, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (busy === 1'b1 && done === 1'b1) overlap_cnt++;
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_run++;
      else if (busy_run != 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
      if (reset) begin
        rx_act = 1'b0;
        rx_cnt = 0;
      end else if (!rx_act) begin
        if (tx === 1'b0) begin
          rx_act = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % CPB == CPB / 2) begin
          rx_bit = rx_cnt / CPB;
          if (rx_bit == 0) begin
            check("rx_start_bit", int'(tx), 0);
          end else if (rx_bit <= 8) begin
            rx_byte = {tx, rx_byte[7:1]};
          end else begin
            check("rx_stop_bit", int'(tx), 1);
            rx_act = 1'b0;
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL rx_unexpected_byte: got 0x%0h, expected no byte", rx_byte);
            end else begin
              rx_exp = exp_q.pop_front();
              if (rx_byte !== rx_exp) begin
                fails++;
                $display("FAIL rx_byte: got 0x%0h, expected 0x%0h", rx_byte, rx_exp);
              end
            end
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic [7:0] cs);
    exp_q.push_back(8'hA5);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
    if (FLEN == 6) exp_q.push_back(cs);
  endtask

  task automatic set_tallies(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d);
    c1 = a;
    c2 = b;
    c3 = c;
    c4 = d;
  endtask

  task automatic do_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 4 * BUSY_LEN; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, int'(got), 1);
  endtask

  task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d, input logic [7:0] cs);
    int dstart;
    set_tallies(a, b, c, d);
    push_frame(a, b, c, d, cs);
    dstart = done_cnt;
    do_start();
    check({name, "_busy_rise"}, int'(busy), 1);
    check({name, "_tx_start"}, int'(tx), 0);
    wait_done(name);
    repeat (3) @(negedge clock);
    check({name, "_busy_len"}, last_busy_len, BUSY_LEN);
    check({name, "_done_pulses"}, done_cnt - dstart, 1);
    check({name, "_bytes_left"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);

    // Basic frame 3,5,0,7 (checksum 01).
    mode = 1'b1;
    run_frame("basic", 8'h03, 8'h05, 8'h00, 8'h07, 8'h01);

    // Voting mode: start must be ignored entirely.
    mode = 1'b0;
    do_start();
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("mode0_lines_idle", bad, 0);

    // Input change and second start mid-frame.
    mode = 1'b1;
    set_tallies(8'h03, 8'h05, 8'h00, 8'h07);
    push_frame(8'h03, 8'h05, 8'h00, 8'h07, 8'h01);
    d0 = done_cnt;
    do_start();
    check("snap_busy_rise", int'(busy), 1);
    repeat (50) @(posedge clock);
    #1 c1 = 8'h09;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done("snap");
    repeat (3) @(negedge clock);
    check("snap_busy_len", last_busy_len, BUSY_LEN);
    bad = 0;
    repeat (100) begin
      @(negedge clock);
      if (busy !== 1'b0) bad++;
    end
    check("snap_no_second_frame", bad, 0);
    check("snap_done_pulses", done_cnt - d0, 1);
    check("snap_bytes_left", exp_q.size(), 0);

    // Reset in the middle of byte 2 abandons the frame.
    set_tallies(8'h12, 8'h34, 8'h56, 8'h78);
    push_frame(8'h12, 8'h34, 8'h56, 8'h78, 8'h08);
    do_start();
    repeat (55) @(posedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    check("midreset_tx", int'(tx), 1);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    repeat (5) @(negedge clock);
    run_frame("after_reset", 8'h12, 8'h34, 8'h56, 8'h78, 8'h08);

    // Mode drop mid-frame, then start held across the done cycle.
    set_tallies(8'hFF, 8'h80, 8'h01, 8'hAA);
    push_frame(8'hFF, 8'h80, 8'h01, 8'hAA, 8'hD4);
    d0 = done_cnt;
    do_start();
    repeat (20) @(posedge clock);
    #1 mode = 1'b0;
    repeat (100) @(posedge clock);
    #1 mode = 1'b1;
    wait_done("mode_drop");
    start = 1'b1;
    @(posedge clock);
    #1 check("start_on_done_ignored", int'(busy), 0);
    set_tallies(8'h03, 8'h05, 8'h00, 8'h07);
    push_frame(8'h03, 8'h05, 8'h00, 8'h07, 8'h01);
    @(posedge clock);
    #1 start = 1'b0;
    check("accept_after_done", int'(busy), 1);
    wait_done("back_to_back");
    repeat (3) @(negedge clock);
    check("b2b_busy_len", last_busy_len, BUSY_LEN);
    check("mode_drop_done_pulses", done_cnt - d0, 2);
    check("mode_drop_bytes_left", exp_q.size(), 0);

    check("busy_done_overlap", overlap_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
